// File: rtl/min_max_loader_pkg.sv
// min_max_loader_pkg: shared defaults, tree-depth derivation and FSM state encoding
// for the min/max operand sequencer.
package min_max_loader_pkg;
    localparam int N_DEF = 4;
    localparam int W_DEF = 7;

    typedef enum logic [1:0] {FILL, RUN, CAPT} state_e;

    function automatic int levels_of(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/min_max_loader_operand_bank.sv
// min_max_loader_operand_bank: N x W slot registers written one at a time by index,
// read out in parallel as a flat vector (slot i in bits [i*W +: W]).
module min_max_loader_operand_bank
    import min_max_loader_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           we_i,
    input  logic [IW-1:0]  idx_i,
    input  logic [W-1:0]   data_i,
    output logic [N*W-1:0] slots_o
);
    logic [W-1:0] slot_q [N];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) slot_q[i] <= '0;
        end else if (we_i) begin
            slot_q[idx_i] <= data_i;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_rd
        assign slots_o[g*W +: W] = slot_q[g];
    end
endmodule

// File: rtl/min_max_loader.sv
// min_max_loader: collects N operands into a vector, strobes the external comparator
// tree once per level, captures the reduced result and offers it on valid/ready.
module min_max_loader
    import min_max_loader_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_in_valid,
    output logic         io_in_ready,
    input  logic [W-1:0] io_in_data,
    output logic         io_cmp_start,
    output logic [W-1:0] io_cmp_inputs [N],
    input  logic [W-1:0] io_cmp_result,
    output logic         io_out_valid,
    input  logic         io_out_ready,
    output logic [W-1:0] io_out_data
);
    localparam int LEVELS = levels_of(N);
    localparam int CW     = $clog2(N + 1);
    localparam int IW     = (N > 1) ? $clog2(N) : 1;
    localparam int LW     = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam logic [LW-1:0] LAST = LW'(LEVELS - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [LW-1:0]  level_q, level_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [N*W-1:0] slots;
    logic           accept, out_free;

    assign io_in_ready  = (state_q == FILL) && (count_q < CW'(N));
    assign io_cmp_start = (state_q == RUN);
    assign accept       = io_in_ready && io_in_valid;
    // The output register is free if empty or being drained this very cycle.
    assign out_free     = !out_valid_q || io_out_ready;
    assign io_out_valid = out_valid_q;
    assign io_out_data  = out_data_q;

    min_max_loader_operand_bank #(.N(N), .W(W), .IW(IW)) u_bank (
        .clock   (clock),
        .reset   (reset),
        .we_i    (accept),
        .idx_i   (count_q[IW-1:0]),
        .data_i  (io_in_data),
        .slots_o (slots)
    );

    for (genvar g = 0; g < N; g++) begin : g_slot
        assign io_cmp_inputs[g] = slots[g*W +: W];
    end

    always_comb begin
        state_d     = state_q;
        count_d     = accept ? count_q + CW'(1) : count_q;
        level_d     = level_q;
        out_valid_d = out_valid_q && !io_out_ready;
        out_data_d  = out_data_q;
        case (state_q)
            FILL: state_d = (count_d == CW'(N) && out_free) ? RUN : FILL;
            RUN: begin
                level_d = (level_q == LAST) ? '0 : level_q + LW'(1);
                state_d = (level_q == LAST) ? CAPT : RUN;
            end
            CAPT: begin
                out_data_d  = io_cmp_result;
                out_valid_d = 1'b1;
                count_d     = '0;
                level_d     = '0;
                state_d     = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            count_q     <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_min_max_loader.sv
// tb_min_max_loader: directed checks of the loader against an external registered
// min tree, for N=4 and N=8.
module tb_min_max_loader;
    logic       clock = 0;
    logic       reset = 0;
    logic       iv4 = 0, ov4, st4, ir4, or4 = 1;
    logic [6:0] id4 = 0, od4, res4;
    logic [6:0] ci4 [4];
    logic       iv8 = 0, ov8, st8, ir8;
    logic [6:0] id8 = 0, od8, res8;
    logic [6:0] ci8 [8];
    logic [6:0] a1 [2];
    logic [6:0] b1 [4];
    logic [6:0] b2 [2];
    int cyc = 0, total = 0, bad = 0, t_a = 0, t_b = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    min_max_loader #(.N(4), .W(7)) u4 (
        .clock(clock), .reset(reset), .io_in_valid(iv4), .io_in_ready(ir4), .io_in_data(id4),
        .io_cmp_start(st4), .io_cmp_inputs(ci4), .io_cmp_result(res4),
        .io_out_valid(ov4), .io_out_ready(or4), .io_out_data(od4)
    );

    min_max_loader #(.N(8), .W(7)) u8 (
        .clock(clock), .reset(reset), .io_in_valid(iv8), .io_in_ready(ir8), .io_in_data(id8),
        .io_cmp_start(st8), .io_cmp_inputs(ci8), .io_cmp_result(res8),
        .io_out_valid(ov8), .io_out_ready(1'b1), .io_out_data(od8)
    );

    function automatic logic [6:0] mn(input logic [6:0] x, input logic [6:0] y);
        return (x < y) ? x : y;
    endfunction

    // Registered min trees: each level advances only while start is high.
    always @(posedge clock) begin
        if (st4) begin
            a1[0] <= mn(ci4[0], ci4[1]);
            a1[1] <= mn(ci4[2], ci4[3]);
            res4  <= mn(a1[0], a1[1]);
        end
        if (st8) begin
            for (int i = 0; i < 4; i++) b1[i] <= mn(ci8[2*i], ci8[2*i+1]);
            for (int i = 0; i < 2; i++) b2[i] <= mn(b1[2*i], b1[2*i+1]);
            res8 <= mn(b2[0], b2[1]);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_slots(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
        chk("slot0", ci4[0], a);
        chk("slot1", ci4[1], b);
        chk("slot2", ci4[2], c);
        chk("slot3", ci4[3], d);
    endtask

    task automatic feed4(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
        logic [6:0] v [4];
        v = '{a, b, c, d};
        iv4 = 1;
        for (int i = 0; i < 4; i++) begin
            id4 = v[i];
            chk("feed_ready", ir4, 1);
            tick();
        end
        iv4 = 0;
    endtask

    initial begin
        logic [6:0] ops8 [8];
        ops8 = '{90, 80, 70, 60, 50, 40, 30, 20};
        // reset state
        #2;
        chk("rst_out_valid", ov4, 0);
        chk("rst_out_data", od4, 0);
        chk("rst_start", st4, 0);
        chk_slots(0, 0, 0, 0);
        #10 reset = 1;
        chk("rel_in_ready", ir4, 1);
        // single vector 40,12,99,7: start in cycles 4-5, result in cycle 7
        feed4(40, 12, 99, 7);
        chk("t1_start_c4", st4, 1);
        chk("t1_ready_c4", ir4, 0);
        chk_slots(40, 12, 99, 7);
        tick();
        chk("t1_start_c5", st4, 1);
        tick();
        chk("t1_start_c6", st4, 0);
        chk("t1_valid_c6", ov4, 0);
        tick();
        chk("t1_valid_c7", ov4, 1);
        chk("t1_data_c7", od4, 7);
        chk("t1_ready_c7", ir4, 1);
        // back-to-back vectors with always-ready sink
        feed4(3, 3, 3, 3);
        tick(); tick(); tick();
        chk("t2_valid_a", ov4, 1);
        chk("t2_data_a", od4, 3);
        t_a = cyc;
        feed4(127, 0, 64, 1);
        tick(); tick(); tick();
        chk("t2_valid_b", ov4, 1);
        chk("t2_data_b", od4, 0);
        t_b = cyc;
        chk("t2_gap", t_b - t_a, 7);
        // backpressure: hold result, next vector stalls at count=N
        or4 = 0;
        feed4(50, 20, 30, 10);
        chk("t3_ready_full", ir4, 0);
        chk("t3_start_held", st4, 0);
        chk("t3_valid_held", ov4, 1);
        chk("t3_data_held", od4, 0);
        chk_slots(50, 20, 30, 10);
        tick();
        chk("t3_start_held2", st4, 0);
        chk("t3_ready_full2", ir4, 0);
        or4 = 1;
        tick();
        chk("t3_start_run", st4, 1);
        chk("t3_valid_taken", ov4, 0);
        tick();
        chk("t3_start_run2", st4, 1);
        tick();
        chk("t3_start_capt", st4, 0);
        tick();
        chk("t3_valid", ov4, 1);
        chk("t3_data", od4, 10);
        // operands every third cycle
        iv4 = 1; id4 = 9;  tick(); iv4 = 0;
        chk("t4_gap_start", st4, 0);
        tick(); tick();
        iv4 = 1; id4 = 25; tick(); iv4 = 0; tick(); tick();
        iv4 = 1; id4 = 5;  tick(); iv4 = 0; tick(); tick();
        chk("t4_ready_gap", ir4, 1);
        iv4 = 1; id4 = 60; tick(); iv4 = 0;
        chk("t4_start1", st4, 1);
        chk_slots(9, 25, 5, 60);
        tick();
        chk("t4_start2", st4, 1);
        tick();
        chk("t4_start_off", st4, 0);
        tick();
        chk("t4_valid", ov4, 1);
        chk("t4_data", od4, 5);
        // asynchronous reset during the second RUN cycle
        feed4(1, 2, 3, 4);
        tick();
        chk("t5_start_pre", st4, 1);
        chk("t5_data_pre", od4, 5);
        #2 reset = 0;
        #1;
        chk("t5_start_rst", st4, 0);
        chk("t5_valid_rst", ov4, 0);
        chk("t5_data_rst", od4, 0);
        #2 reset = 1;
        chk("t5_ready_rel", ir4, 1);
        chk_slots(0, 0, 0, 0);
        feed4(8, 6, 7, 9);
        tick(); tick(); tick();
        chk("t5_valid", ov4, 1);
        chk("t5_data", od4, 6);
        // N=8: three start cycles, result at t+5
        iv8 = 1;
        for (int i = 0; i < 8; i++) begin
            id8 = ops8[i];
            chk("t6_ready", ir8, 1);
            tick();
        end
        iv8 = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_start", st8, 1);
            tick();
        end
        chk("t6_start_off", st8, 0);
        chk("t6_valid_capt", ov8, 0);
        tick();
        chk("t6_valid", ov8, 1);
        chk("t6_data", od8, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
